// File: rtl/gates_stim_check.sv
// BIST sequencer for the AND/XOR/OR gates stage: sweeps all four operand pairs, checks x/y/z.
// Optional fail_mask_o output is enabled by defining GATES_STIM_CHECK_FAILMASK_EN.
module gates_stim_check #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  output logic       a_o,
  output logic       b_o,
  input  logic       x_i,
  input  logic       y_i,
  input  logic       z_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] err_count_o,
  output logic [1:0] case_idx_o,
  output logic       mismatch_o
`ifdef GATES_STIM_CHECK_FAILMASK_EN
  ,
  output logic [3:0] fail_mask_o
`endif
);

  localparam int unsigned SetW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned PassW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SetW-1:0]  SetLast  = SetW'(SETTLE_CYCLES - 1);
  localparam logic [PassW-1:0] PassLast = PassW'(PASSES - 1);

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StSample, StDone} state_e;

  state_e           state_q, state_d;
  logic             a_q, a_d, b_q, b_d;
  logic [7:0]       err_q, err_d;
  logic             mismatch_q, mismatch_d;
  logic [SetW-1:0]  set_cnt_q, set_cnt_d;
  logic [PassW-1:0] pass_cnt_q, pass_cnt_d;
  logic             accept, case_fail;

  assign accept    = ((state_q == StIdle) || (state_q == StDone)) && start_i;
  // One verdict per case, however many of the three bits are wrong.
  assign case_fail = ({x_i, y_i, z_i} != {a_q & b_q, a_q ^ b_q, a_q | b_q});

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    err_d      = err_q;
    mismatch_d = 1'b0;
    set_cnt_d  = set_cnt_q;
    pass_cnt_d = pass_cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d    = StDrive;
          a_d        = 1'b0;
          b_d        = 1'b0;
          err_d      = 8'd0;
          pass_cnt_d = '0;
        end
      end
      StDrive: begin
        set_cnt_d = '0;
        state_d   = (SETTLE_CYCLES == 0) ? StSample : StSettle;
      end
      StSettle: begin
        if (set_cnt_q == SetLast) state_d = StSample;
        else                      set_cnt_d = set_cnt_q + SetW'(1);
      end
      StSample: begin
        if (case_fail) begin
          mismatch_d = 1'b1;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
        state_d = StDrive;
        if ({b_q, a_q} == 2'd3) begin
          if (pass_cnt_q == PassLast) begin
            state_d = StDone;
          end else begin
            pass_cnt_d = pass_cnt_q + PassW'(1);
            a_d        = 1'b0;
            b_d        = 1'b0;
          end
        end else begin
          // Inner loop on a, outer on b.
          a_d = ~a_q;
          b_d = b_q ^ a_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      err_q      <= 8'd0;
      mismatch_q <= 1'b0;
      set_cnt_q  <= '0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
      set_cnt_q  <= set_cnt_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

`ifdef GATES_STIM_CHECK_FAILMASK_EN
  logic [3:0] fail_mask_q, fail_mask_d;

  always_comb begin
    fail_mask_d = fail_mask_q;
    if (accept) begin
      fail_mask_d = 4'd0;
    end else if ((state_q == StSample) && case_fail) begin
      fail_mask_d[{b_q, a_q}] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) fail_mask_q <= 4'd0;
    else         fail_mask_q <= fail_mask_d;
  end

  assign fail_mask_o = fail_mask_q;
`endif

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign busy_o      = (state_q == StDrive) || (state_q == StSettle) || (state_q == StSample);
  assign done_o      = (state_q == StDone);
  assign pass_o      = done_o && (err_q == 8'd0);
  assign err_count_o = err_q;
  assign case_idx_o  = {b_q, a_q};
  assign mismatch_o  = mismatch_q;

endmodule

// File: tb/tb_gates_stim_check.sv
// Bench for gates_stim_check: four configurations driven by a gates model with injectable bit flips.
module tb_gates_stim_check;

  localparam int SC [4] = '{2, 2, 2, 0};
  localparam int PS [4] = '{1, 2, 70, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [4];
  logic       a_w [4], b_w [4], x_w [4], y_w [4], z_w [4];
  logic       busy_w [4], done_w [4], pass_w [4], mm_w [4];
  logic [7:0] err_w [4];
  logic [1:0] idx_w [4];
  logic [3:0] fm_w [4];
  logic [2:0] flip [4][4];
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  // Gates stage stand-in: golden result XOR a per-case fault pattern {x,y,z}.
  for (genvar k = 0; k < 4; k++) begin : g_model
    assign {x_w[k], y_w[k], z_w[k]} = {a_w[k] & b_w[k], a_w[k] ^ b_w[k], a_w[k] | b_w[k]}
                                      ^ flip[k][{b_w[k], a_w[k]}];
`ifndef GATES_STIM_CHECK_FAILMASK_EN
    assign fm_w[k] = 4'd0;
`endif
  end

  gates_stim_check #(.SETTLE_CYCLES(2), .PASSES(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .a_o(a_w[0]), .b_o(b_w[0]),
    .x_i(x_w[0]), .y_i(y_w[0]), .z_i(z_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]),
    .pass_o(pass_w[0]), .err_count_o(err_w[0]), .case_idx_o(idx_w[0]), .mismatch_o(mm_w[0])
`ifdef GATES_STIM_CHECK_FAILMASK_EN
    , .fail_mask_o(fm_w[0])
`endif
  );

  gates_stim_check #(.SETTLE_CYCLES(2), .PASSES(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .a_o(a_w[1]), .b_o(b_w[1]),
    .x_i(x_w[1]), .y_i(y_w[1]), .z_i(z_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]),
    .pass_o(pass_w[1]), .err_count_o(err_w[1]), .case_idx_o(idx_w[1]), .mismatch_o(mm_w[1])
`ifdef GATES_STIM_CHECK_FAILMASK_EN
    , .fail_mask_o(fm_w[1])
`endif
  );

  gates_stim_check #(.SETTLE_CYCLES(2), .PASSES(70)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .a_o(a_w[2]), .b_o(b_w[2]),
    .x_i(x_w[2]), .y_i(y_w[2]), .z_i(z_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]),
    .pass_o(pass_w[2]), .err_count_o(err_w[2]), .case_idx_o(idx_w[2]), .mismatch_o(mm_w[2])
`ifdef GATES_STIM_CHECK_FAILMASK_EN
    , .fail_mask_o(fm_w[2])
`endif
  );

  gates_stim_check #(.SETTLE_CYCLES(0), .PASSES(1)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[3]), .a_o(a_w[3]), .b_o(b_w[3]),
    .x_i(x_w[3]), .y_i(y_w[3]), .z_i(z_w[3]), .busy_o(busy_w[3]), .done_o(done_w[3]),
    .pass_o(pass_w[3]), .err_count_o(err_w[3]), .case_idx_o(idx_w[3]), .mismatch_o(mm_w[3])
`ifdef GATES_STIM_CHECK_FAILMASK_EN
    , .fail_mask_o(fm_w[3])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, " a"}, 32'(a_w[k]), 0);
    chk({tag, " b"}, 32'(b_w[k]), 0);
    chk({tag, " busy"}, 32'(busy_w[k]), 0);
    chk({tag, " done"}, 32'(done_w[k]), 0);
    chk({tag, " pass"}, 32'(pass_w[k]), 0);
    chk({tag, " mismatch"}, 32'(mm_w[k]), 0);
    chk({tag, " case_idx"}, 32'(idx_w[k]), 0);
    chk({tag, " err_count"}, 32'(err_w[k]), 0);
    chk({tag, " fail_mask"}, 32'(fm_w[k]), 0);
  endtask

  task automatic set_flips(input int k, input logic [2:0] f0, input logic [2:0] f1,
                           input logic [2:0] f2, input logic [2:0] f3);
    flip[k][0] = f0; flip[k][1] = f1; flip[k][2] = f2; flip[k][3] = f3;
  endtask

  // Start one run on instance k and follow it to DONE against a timeline model.
  task automatic run(input int k, input string tag);
    int         len, total, nf, exp_err, mm_cnt, q;
    logic [3:0] exp_mask;
    logic [1:0] c;
    logic       exp_mm;
    len      = SC[k] + 2;
    total    = 4 * PS[k] * len;
    nf       = 0;
    exp_mask = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (flip[k][i] != 3'd0) begin
        nf++;
        exp_mask[i] = 1'b1;
      end
    end
    exp_err = (PS[k] * nf > 255) ? 255 : PS[k] * nf;
    mm_cnt  = 0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= total; t++) begin
      if (t > 0) @(negedge clk);
      if (t < total) begin
        q = t / len;
        c = 2'(q % 4);
        chk({tag, " busy"}, 32'(busy_w[k]), 1);
        chk({tag, " done"}, 32'(done_w[k]), 0);
        chk({tag, " case_idx"}, 32'(idx_w[k]), 32'(c));
        chk({tag, " a"}, 32'(a_w[k]), 32'(c[0]));
        chk({tag, " b"}, 32'(b_w[k]), 32'(c[1]));
      end else begin
        chk({tag, " busy end"}, 32'(busy_w[k]), 0);
        chk({tag, " done end"}, 32'(done_w[k]), 1);
        chk({tag, " case_idx end"}, 32'(idx_w[k]), 3);
        chk({tag, " a end"}, 32'(a_w[k]), 1);
        chk({tag, " b end"}, 32'(b_w[k]), 1);
      end
      if (t == 0) chk({tag, " err cleared"}, 32'(err_w[k]), 0);
      exp_mm = 1'b0;
      if (t > 0 && (t % len) == 0) exp_mm = (flip[k][((t / len) - 1) % 4] != 3'd0);
      chk({tag, " mismatch"}, 32'(mm_w[k]), 32'(exp_mm));
      if (mm_w[k] === 1'b1) mm_cnt++;
      // Random start requests while busy must be ignored.
      start[k] = (t < total) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    chk({tag, " err_count"}, 32'(err_w[k]), 32'(exp_err));
    chk({tag, " pass"}, 32'(pass_w[k]), 32'(exp_err == 0));
    chk({tag, " pulse count"}, 32'(mm_cnt), 32'(PS[k] * nf));
`ifdef GATES_STIM_CHECK_FAILMASK_EN
    chk({tag, " fail_mask"}, 32'(fm_w[k]), 32'(exp_mask));
`endif
    @(negedge clk);
    chk({tag, " done held"}, 32'(done_w[k]), 1);
    chk({tag, " mismatch idle"}, 32'(mm_w[k]), 0);
    chk({tag, " err held"}, 32'(err_w[k]), 32'(exp_err));
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      start[k] = 1'b0;
      set_flips(k, 3'd0, 3'd0, 3'd0, 3'd0);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) chk_zero(k, "reset");
    rst_n = 1'b1;

    run(0, "golden");
    set_flips(0, 3'd0, 3'd0, 3'd0, 3'b100);
    run(0, "x_stuck0");
    set_flips(0, 3'd0, 3'd0, 3'd0, 3'd0);
    run(0, "restart_golden");

    set_flips(1, 3'b010, 3'b010, 3'b010, 3'b010);
    run(1, "y_inv_passes2");

    run(3, "settle0_golden");
    for (int i = 0; i < 4; i++) flip[3][i] = 3'($urandom_range(0, 7));
    run(3, "settle0_random");

    set_flips(2, 3'b111, 3'b111, 3'b111, 3'b111);
    run(2, "saturate");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) flip[0][i] = 3'($urandom_range(0, 7));
      run(0, "random_faults");
    end

    // Abort during the SETTLE phase of case 2.
    set_flips(0, 3'd0, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2 * (SC[0] + 2) + 1) @(negedge clk);
    chk("midrun case_idx", 32'(idx_w[0]), 2);
    chk("midrun busy", 32'(busy_w[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero(0, "midrun reset");
    @(negedge clk);
    chk("after reset busy", 32'(busy_w[0]), 0);
    chk("after reset done", 32'(done_w[0]), 0);
    run(0, "post_reset_golden");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gates_stim_check.md
Name: gates_stim_check

Overview:
- Self-checking sequencer wrapped around the two-input gates stage (AND/XOR/OR outputs x, y, z).
- Upstream role: drives operands a, b through every input combination.
- Downstream role: samples x, y, z after a settle window and compares them against expected values.
- Counts mismatches and reports pass/fail. Used as on-chip BIST and as a reusable bench stage.

Parameters:
- SETTLE_CYCLES, 2, cycles held between driving a/b and sampling x/y/z (0 allowed).
- PASSES, 1, number of full 4-case sweeps per run (must be >= 1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- a  out  1  operand A to gates stage
- b  out  1  operand B to gates stage
- x  in  1  gates AND result
- y  in  1  gates XOR result
- z  in  1  gates OR result
- busy  out  1  run in progress
- done  out  1  run complete; held until next start
- pass  out  1  valid when done=1; 1 iff err_count==0
- err_count  out  8  mismatching cases, saturates at 255
- case_idx  out  2  current case = 2*b+a
- mismatch  out  1  one-cycle pulse per failing case

Behaviour:
- Reset, sampled on a clk edge while rst_n=0, applies from any state including mid-run:
  - state goes to IDLE.
  - a, b, busy, done, pass, mismatch, case_idx and err_count are all 0.
  - Internal pass and settle counters are cleared.
- Case order: (a,b) = (0,0), (1,0), (0,1), (1,1). Outer loop is b, inner loop is a; case_idx = 0, 1, 2, 3.
- IDLE:
  - a=b=0, busy=0.
  - start=1 -> DRIVE: clear err_count, load case 0, busy=1, done=0.
- DRIVE: one cycle with a/b stable -> SETTLE, or -> SAMPLE if SETTLE_CYCLES=0.
- SETTLE: hold for SETTLE_CYCLES cycles -> SAMPLE.
- SAMPLE (one cycle):
  - Expected values from the registered a/b: x=a&b, y=a^b, z=a|b.
  - Any bit differs: err_count+1 (saturating at 255), and mismatch=1 for the following cycle.
  - One count per failing case, not per failing bit.
  - Exit: not last case -> DRIVE with the next case. Last case and not last pass -> DRIVE with case 0, pass counter +1. Otherwise -> DONE.
- DONE:
  - busy=0, done=1, pass=(err_count==0). a, b and case_idx hold their last values.
  - start=1 -> DRIVE exactly as from IDLE: clears err_count, done drops the next cycle.
- start while busy is ignored.
- Latency: each case takes 2+SETTLE_CYCLES cycles. done rises 4*PASSES*(2+SETTLE_CYCLES) edges after the accepting edge; 16 with defaults.
- x/y/z are assumed combinational from a/b; SETTLE_CYCLES absorbs any downstream registering.

Optional Feature:
- Macro GATES_STIM_CHECK_FAILMASK_EN.
- Defined:
  - Adds output fail_mask [3:0]. Bit k is set sticky when case k mismatches in any pass.
  - fail_mask is cleared by reset and by an accepted start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Golden gates model, defaults, start pulse:
  - a/b step 00, 10, 01, 11; case_idx steps 0..3.
  - done=1 after 16 edges; err_count=0, pass=1, no mismatch pulses.
- Faulty model with x stuck at 0:
  - Only case 3 fails: one mismatch pulse, err_count=1, pass=0.
  - With the macro: fail_mask=4'b1000.
- Faulty model with y inverted, PASSES=2: err_count=8, pass=0, done after 32 edges.
- Reset mid-run:
  - rst_n=0 for one edge during case 2 SETTLE -> all outputs 0, state IDLE.
  - A new start then completes normally with err_count=0.
- Restart from DONE after a failing run: start=1 -> err_count clears to 0 and done drops; a golden model then yields pass=1.
- Saturation: PASSES=70, all outputs inverted (280 failing cases) -> err_count=255, pass=0.
- SETTLE_CYCLES=0: each case takes 2 cycles; done after 8 edges; results correct.
